// File: rtl/mwrite.sv
`default_nettype none
// ============================================================================
//  Module   : mwrite
//  Purpose  : Memory-write / writeback stage. It registers the read-stage
//             results and owns the single-outstanding store to the MMU.
//  Revision : 1.0 - initial release
// ============================================================================
module mwrite #(
    parameter int         WR_TIMEOUT      = 255,
    parameter logic [3:0] EXC_STORE_FAULT = 4'd7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        MEM_WAIT,
    output logic        WR_BUSY,
    output logic        DATA_WREN,
    output logic [31:0] DATA_WADDR,
    output logic [31:0] DATA_WDATA,
    input  logic        DATA_WREADY,
    input  logic [4:0]  MEMR_REG_W_RD,
    input  logic [31:0] MEMR_REG_W_DATA,
    input  logic        MEMR_CSR_W_EN,
    input  logic [11:0] MEMR_CSR_W_ADDR,
    input  logic [31:0] MEMR_CSR_W_DATA,
    input  logic        MEMR_MEM_W_EN,
    input  logic [31:0] MEMR_MEM_W_ADDR,
    input  logic [31:0] MEMR_MEM_W_DATA,
    input  logic        MEMR_JMP_DO,
    input  logic [31:0] MEMR_JMP_PC,
    input  logic        MEMR_EXC_EN,
    input  logic [3:0]  MEMR_EXC_CODE,
    output logic [4:0]  MEMW_REG_W_RD,
    output logic [31:0] MEMW_REG_W_DATA,
    output logic        MEMW_CSR_W_EN,
    output logic [11:0] MEMW_CSR_W_ADDR,
    output logic [31:0] MEMW_CSR_W_DATA,
    output logic        MEMW_JMP_DO,
    output logic [31:0] MEMW_JMP_PC,
    output logic        MEMW_EXC_EN,
    output logic [3:0]  MEMW_EXC_CODE
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [7:0] c_to_last = 8'(WR_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        w_load;
    logic        w_fault_nxt;
    logic        r_fault;
    logic        w_busy;
    logic        w_cap;
    logic        w_start;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;

    logic [4:0]  r_reg_rd;
    logic [31:0] r_reg_data;
    logic        r_csr_en;
    logic [11:0] r_csr_addr;
    logic [31:0] r_csr_data;
    logic        r_jmp_do;
    logic [31:0] r_jmp_pc;
    logic        r_exc_en;
    logic [3:0]  r_exc_code;

    // Byte offset is dropped; the bus only sees word addresses.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = &{1'b0, MEMR_MEM_W_ADDR[1:0]};

    assign w_busy  = (r_state == S_REQ) && !DATA_WREADY;
    assign w_cap   = !MEM_WAIT && !w_busy;
    assign w_start = w_cap && MEMR_MEM_W_EN && !MEMR_EXC_EN && !FLUSH;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_fault_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_REQ;
                    w_cnt_nxt   = 8'd0;
                    w_load      = 1'b1;
                end
            end
            S_REQ: begin
                // Acceptance beats timeout; a store captured on the accept
                // cycle re-enters REQ without an idle bubble.
                if (DATA_WREADY) begin
                    if (w_start) begin
                        w_cnt_nxt = 8'd0;
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_cnt == c_to_last) begin
                    w_state_nxt = S_IDLE;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_fault <= 1'b0;
            r_waddr <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
            if (w_load) begin
                r_waddr <= {MEMR_MEM_W_ADDR[31:2], 2'b00};
                r_wdata <= MEMR_MEM_W_DATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST || FLUSH) begin
            r_reg_rd   <= 5'd0;
            r_reg_data <= 32'd0;
            r_csr_en   <= 1'b0;
            r_csr_addr <= 12'd0;
            r_csr_data <= 32'd0;
            r_jmp_do   <= 1'b0;
            r_jmp_pc   <= 32'd0;
            r_exc_en   <= 1'b0;
            r_exc_code <= 4'd0;
        end else if (w_cap) begin
            r_reg_rd   <= MEMR_REG_W_RD;
            r_reg_data <= MEMR_REG_W_DATA;
            r_csr_en   <= MEMR_CSR_W_EN;
            r_csr_addr <= MEMR_CSR_W_ADDR;
            r_csr_data <= MEMR_CSR_W_DATA;
            r_jmp_do   <= MEMR_JMP_DO;
            r_jmp_pc   <= MEMR_JMP_PC;
            r_exc_en   <= MEMR_EXC_EN;
            r_exc_code <= MEMR_EXC_CODE;
        end
    end

    assign WR_BUSY         = w_busy;
    assign DATA_WREN       = (r_state == S_REQ);
    assign DATA_WADDR      = r_waddr;
    assign DATA_WDATA      = r_wdata;
    assign MEMW_REG_W_RD   = r_reg_rd;
    assign MEMW_REG_W_DATA = r_reg_data;
    assign MEMW_CSR_W_EN   = r_csr_en;
    assign MEMW_CSR_W_ADDR = r_csr_addr;
    assign MEMW_CSR_W_DATA = r_csr_data;
    assign MEMW_JMP_DO     = r_jmp_do;
    assign MEMW_JMP_PC     = r_jmp_pc;
    // A store timeout shows as a one-cycle fault over the held exception.
    assign MEMW_EXC_EN     = r_fault | r_exc_en;
    assign MEMW_EXC_CODE   = r_fault ? EXC_STORE_FAULT : r_exc_code;

endmodule
`default_nettype wire

// File: tb/tb_mwrite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mwrite
//  Purpose  : Directed self-checking bench for the mwrite stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mwrite;

    logic        CLK;
    logic        RST;
    logic        FLUSH;
    logic        MEM_WAIT;
    logic        WR_BUSY;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        DATA_WREADY;
    logic [4:0]  MEMR_REG_W_RD;
    logic [31:0] MEMR_REG_W_DATA;
    logic        MEMR_CSR_W_EN;
    logic [11:0] MEMR_CSR_W_ADDR;
    logic [31:0] MEMR_CSR_W_DATA;
    logic        MEMR_MEM_W_EN;
    logic [31:0] MEMR_MEM_W_ADDR;
    logic [31:0] MEMR_MEM_W_DATA;
    logic        MEMR_JMP_DO;
    logic [31:0] MEMR_JMP_PC;
    logic        MEMR_EXC_EN;
    logic [3:0]  MEMR_EXC_CODE;
    logic [4:0]  MEMW_REG_W_RD;
    logic [31:0] MEMW_REG_W_DATA;
    logic        MEMW_CSR_W_EN;
    logic [11:0] MEMW_CSR_W_ADDR;
    logic [31:0] MEMW_CSR_W_DATA;
    logic        MEMW_JMP_DO;
    logic [31:0] MEMW_JMP_PC;
    logic        MEMW_EXC_EN;
    logic [3:0]  MEMW_EXC_CODE;

    int n_tests = 0;
    int n_fail  = 0;

    mwrite #(
        .WR_TIMEOUT      (4),
        .EXC_STORE_FAULT (4'd7)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .FLUSH           (FLUSH),
        .MEM_WAIT        (MEM_WAIT),
        .WR_BUSY         (WR_BUSY),
        .DATA_WREN       (DATA_WREN),
        .DATA_WADDR      (DATA_WADDR),
        .DATA_WDATA      (DATA_WDATA),
        .DATA_WREADY     (DATA_WREADY),
        .MEMR_REG_W_RD   (MEMR_REG_W_RD),
        .MEMR_REG_W_DATA (MEMR_REG_W_DATA),
        .MEMR_CSR_W_EN   (MEMR_CSR_W_EN),
        .MEMR_CSR_W_ADDR (MEMR_CSR_W_ADDR),
        .MEMR_CSR_W_DATA (MEMR_CSR_W_DATA),
        .MEMR_MEM_W_EN   (MEMR_MEM_W_EN),
        .MEMR_MEM_W_ADDR (MEMR_MEM_W_ADDR),
        .MEMR_MEM_W_DATA (MEMR_MEM_W_DATA),
        .MEMR_JMP_DO     (MEMR_JMP_DO),
        .MEMR_JMP_PC     (MEMR_JMP_PC),
        .MEMR_EXC_EN     (MEMR_EXC_EN),
        .MEMR_EXC_CODE   (MEMR_EXC_CODE),
        .MEMW_REG_W_RD   (MEMW_REG_W_RD),
        .MEMW_REG_W_DATA (MEMW_REG_W_DATA),
        .MEMW_CSR_W_EN   (MEMW_CSR_W_EN),
        .MEMW_CSR_W_ADDR (MEMW_CSR_W_ADDR),
        .MEMW_CSR_W_DATA (MEMW_CSR_W_DATA),
        .MEMW_JMP_DO     (MEMW_JMP_DO),
        .MEMW_JMP_PC     (MEMW_JMP_PC),
        .MEMW_EXC_EN     (MEMW_EXC_EN),
        .MEMW_EXC_CODE   (MEMW_EXC_CODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        MEMR_REG_W_RD   = 5'd0;
        MEMR_REG_W_DATA = 32'd0;
        MEMR_CSR_W_EN   = 1'b0;
        MEMR_CSR_W_ADDR = 12'd0;
        MEMR_CSR_W_DATA = 32'd0;
        MEMR_MEM_W_EN   = 1'b0;
        MEMR_MEM_W_ADDR = 32'd0;
        MEMR_MEM_W_DATA = 32'd0;
        MEMR_JMP_DO     = 1'b0;
        MEMR_JMP_PC     = 32'd0;
        MEMR_EXC_EN     = 1'b0;
        MEMR_EXC_CODE   = 4'd0;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
        drive_idle();
        MEMR_MEM_W_EN   = 1'b1;
        MEMR_MEM_W_ADDR = addr;
        MEMR_MEM_W_DATA = data;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++; if (DATA_WREN !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", DATA_WREN); end
        n_tests++; if (WR_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", WR_BUSY); end
        n_tests++; if (DATA_WADDR !== 32'd0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", DATA_WADDR); end
        n_tests++; if ({MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_EXC_EN, MEMW_EXC_CODE, MEMW_JMP_DO, MEMW_CSR_W_EN} !== 43'd0) begin
            n_fail++; $display("FAIL reset_memw: rd=%0d data=%h exc=%b code=%0d", MEMW_REG_W_RD, MEMW_REG_W_DATA, MEMW_EXC_EN, MEMW_EXC_CODE);
        end
        @(negedge CLK) RST = 1'b1;
        step();
    endtask

    task automatic test_single_store();
        drive_store(32'h0000_1003, 32'hAABB_CCDD);
        step();
        drive_idle();
        #1;
        n_tests++; if (DATA_WREN !== 1'b1) begin n_fail++; $display("FAIL single_wren: got %b want 1", DATA_WREN); end
        n_tests++; if (DATA_WADDR !== 32'h0000_1000) begin n_fail++; $display("FAIL single_waddr: got %h want 00001000", DATA_WADDR); end
        n_tests++; if (DATA_WDATA !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL single_wdata: got %h want aabbccdd", DATA_WDATA); end
        n_tests++; if (WR_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy1: got %b want 1", WR_BUSY); end
        step();
        n_tests++; if (WR_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy2: got %b want 1", WR_BUSY); end
        step();
        DATA_WREADY = 1'b1;
        #1;
        n_tests++; if (WR_BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy3: got %b want 0", WR_BUSY); end
        n_tests++; if (DATA_WREN !== 1'b1) begin n_fail++; $display("FAIL single_wren3: got %b want 1", DATA_WREN); end
        step();
        DATA_WREADY = 1'b0;
        #1;
        n_tests++; if (DATA_WREN !== 1'b0) begin n_fail++; $display("FAIL single_done: got %b want 0", DATA_WREN); end
    endtask

    task automatic test_back_to_back();
        DATA_WREADY = 1'b1;
        drive_store(32'h0000_0010, 32'h1111_1111);
        step();
        drive_store(32'h0000_0014, 32'h2222_2222);
        #1;
        n_tests++; if (DATA_WREN !== 1'b1 || DATA_WADDR !== 32'h10) begin
            n_fail++; $display("FAIL b2b_first: wren=%b addr=%h want 1/00000010", DATA_WREN, DATA_WADDR);
        end
        n_tests++; if (WR_BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", WR_BUSY); end
        step();
        drive_idle();
        #1;
        n_tests++; if (DATA_WREN !== 1'b1 || DATA_WADDR !== 32'h14 || DATA_WDATA !== 32'h2222_2222) begin
            n_fail++; $display("FAIL b2b_second: wren=%b addr=%h data=%h want 1/00000014/22222222", DATA_WREN, DATA_WADDR, DATA_WDATA);
        end
        step();
        DATA_WREADY = 1'b0;
        #1;
        n_tests++; if (DATA_WREN !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %b want 0", DATA_WREN); end
    endtask

    task automatic test_timeout();
        drive_store(32'h0000_0020, 32'h3333_3333);
        step();
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (DATA_WREN !== 1'b1 || MEMW_EXC_EN !== 1'b0) begin
                n_fail++; $display("FAIL timeout_req%0d: wren=%b exc=%b want 1/0", i, DATA_WREN, MEMW_EXC_EN);
            end
            step();
        end
        #1;
        n_tests++; if (DATA_WREN !== 1'b0) begin n_fail++; $display("FAIL timeout_wren: got %b want 0", DATA_WREN); end
        n_tests++; if (MEMW_EXC_EN !== 1'b1 || MEMW_EXC_CODE !== 4'd7) begin
            n_fail++; $display("FAIL timeout_fault: exc=%b code=%0d want 1/7", MEMW_EXC_EN, MEMW_EXC_CODE);
        end
        step();
        n_tests++; if (MEMW_EXC_EN !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", MEMW_EXC_EN); end
    endtask

    task automatic test_flush();
        drive_store(32'h0000_0040, 32'h5555_5555);
        MEMR_REG_W_RD   = 5'd3;
        MEMR_REG_W_DATA = 32'h0000_DEAD;
        step();
        drive_idle();
        FLUSH = 1'b1;
        #1;
        n_tests++; if (MEMW_REG_W_RD !== 5'd3) begin n_fail++; $display("FAIL flush_pre: got %0d want 3", MEMW_REG_W_RD); end
        step();
        FLUSH = 1'b0;
        #1;
        n_tests++; if (MEMW_REG_W_RD !== 5'd0 || MEMW_REG_W_DATA !== 32'd0) begin
            n_fail++; $display("FAIL flush_clear: rd=%0d data=%h want 0/0", MEMW_REG_W_RD, MEMW_REG_W_DATA);
        end
        n_tests++; if (DATA_WREN !== 1'b1) begin n_fail++; $display("FAIL flush_wren: got %b want 1", DATA_WREN); end
        step();
        DATA_WREADY = 1'b1;
        #1;
        n_tests++; if (DATA_WREN !== 1'b1 || DATA_WADDR !== 32'h40 || WR_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL flush_accept: wren=%b addr=%h busy=%b want 1/00000040/0", DATA_WREN, DATA_WADDR, WR_BUSY);
        end
        step();
        DATA_WREADY = 1'b0;
        #1;
        n_tests++; if (DATA_WREN !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", DATA_WREN); end
    endtask

    task automatic test_passthrough();
        drive_idle();
        MEMR_REG_W_RD   = 5'd5;
        MEMR_REG_W_DATA = 32'h0000_1234;
        step();
        MEM_WAIT        = 1'b1;
        MEMR_REG_W_RD   = 5'd9;
        MEMR_REG_W_DATA = 32'h0000_9999;
        #1;
        n_tests++; if (MEMW_REG_W_RD !== 5'd5 || MEMW_REG_W_DATA !== 32'h1234) begin
            n_fail++; $display("FAIL pass_wb: rd=%0d data=%h want 5/00001234", MEMW_REG_W_RD, MEMW_REG_W_DATA);
        end
        step();
        n_tests++; if (MEMW_REG_W_RD !== 5'd5 || MEMW_REG_W_DATA !== 32'h1234) begin
            n_fail++; $display("FAIL pass_hold: rd=%0d data=%h want 5/00001234", MEMW_REG_W_RD, MEMW_REG_W_DATA);
        end
        MEM_WAIT = 1'b0;
        step();
        n_tests++; if (MEMW_REG_W_RD !== 5'd9) begin n_fail++; $display("FAIL pass_resume: got %0d want 9", MEMW_REG_W_RD); end
        drive_store(32'h0000_0050, 32'h6666_6666);
        MEMR_EXC_EN     = 1'b1;
        MEMR_EXC_CODE   = 4'd6;
        MEMR_CSR_W_EN   = 1'b1;
        MEMR_CSR_W_ADDR = 12'h300;
        MEMR_CSR_W_DATA = 32'h0000_CAFE;
        MEMR_JMP_DO     = 1'b1;
        MEMR_JMP_PC     = 32'h0000_8000;
        step();
        drive_idle();
        #1;
        n_tests++; if (DATA_WREN !== 1'b0) begin n_fail++; $display("FAIL exc_nowrite: got %b want 0", DATA_WREN); end
        n_tests++; if (MEMW_EXC_EN !== 1'b1 || MEMW_EXC_CODE !== 4'd6) begin
            n_fail++; $display("FAIL exc_pass: exc=%b code=%0d want 1/6", MEMW_EXC_EN, MEMW_EXC_CODE);
        end
        n_tests++; if (MEMW_CSR_W_EN !== 1'b1 || MEMW_CSR_W_ADDR !== 12'h300 || MEMW_CSR_W_DATA !== 32'hCAFE) begin
            n_fail++; $display("FAIL csr_pass: en=%b addr=%h data=%h want 1/300/0000cafe", MEMW_CSR_W_EN, MEMW_CSR_W_ADDR, MEMW_CSR_W_DATA);
        end
        n_tests++; if (MEMW_JMP_DO !== 1'b1 || MEMW_JMP_PC !== 32'h8000) begin
            n_fail++; $display("FAIL jmp_pass: do=%b pc=%h want 1/00008000", MEMW_JMP_DO, MEMW_JMP_PC);
        end
        step();
        n_tests++; if (MEMW_EXC_EN !== 1'b0) begin n_fail++; $display("FAIL exc_clear: got %b want 0", MEMW_EXC_EN); end
    endtask

    task automatic test_reset_mid_store();
        drive_store(32'h0000_0080, 32'h7777_7777);
        MEMR_REG_W_RD = 5'd7;
        step();
        drive_idle();
        #1;
        n_tests++; if (DATA_WREN !== 1'b1 || MEMW_REG_W_RD !== 5'd7) begin
            n_fail++; $display("FAIL rstmid_pre: wren=%b rd=%0d want 1/7", DATA_WREN, MEMW_REG_W_RD);
        end
        RST = 1'b0;
        #1;
        n_tests++; if (DATA_WREN !== 1'b0 || WR_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: wren=%b busy=%b want 0/0", DATA_WREN, WR_BUSY);
        end
        n_tests++; if (MEMW_REG_W_RD !== 5'd0 || DATA_WADDR !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_clear: rd=%0d addr=%h want 0/0", MEMW_REG_W_RD, DATA_WADDR);
        end
        @(negedge CLK) RST = 1'b1;
        step();
        n_tests++; if (DATA_WREN !== 1'b0 || WR_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: wren=%b busy=%b want 0/0", DATA_WREN, WR_BUSY);
        end
    endtask

    initial begin
        FLUSH       = 1'b0;
        MEM_WAIT    = 1'b0;
        DATA_WREADY = 1'b0;
        drive_idle();
        test_reset();
        test_single_store();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_passthrough();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
